store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/riscproc_pkg.sv | 11 +
 rtl/sb_fwd_match.sv | 34 +++
 rtl/store_buffer.sv | 90 +++++++++
 tb/tb_store_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscproc_pkg.sv
// Shared processor definitions: store buffer default depth and entry layout.
package riscproc_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding search: finds the youngest valid buffered entry
// whose address matches the load address.
module sb_fwd_match
  import riscproc_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t [DEPTH-1:0]         entries,
  input  logic      [DEPTH-1:0]         valid,
  input  logic      [$clog2(DEPTH)-1:0] tail,
  input  logic      [7:0]               ld_addr,
  output logic                          hit,
  output logic      [7:0]               data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk from oldest slot (tail - DEPTH) to youngest (tail - 1); later matches win.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (valid[idx] && (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between core and data memory, draining one store per
// cycle in program order and forwarding buffered data to loads.
module store_buffer
  import riscproc_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [7:0]               st_addr,
  input  logic [7:0]               st_data,
  output logic                     st_ready,
  input  logic                     drain_stall,
  input  logic [7:0]               ld_addr,
  output logic [7:0]               ld_data,
  input  logic [7:0]               dm_out,
  output logic [7:0]               rmi,
  output logic                     mem_write,
  output logic [7:0]               rmo,
  output logic [7:0]               wr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] valid;
  logic      [PTR_W-1:0] head;
  logic      [PTR_W-1:0] tail;
  logic      [CNT_W-1:0] cnt;
  logic                  push;
  logic                  pop;
  logic                  fwd_hit;
  logic      [7:0]       fwd_data;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign count     = cnt;
  assign st_ready  = !full;
  assign push      = st_valid && st_ready;
  assign mem_write = !empty && !drain_stall;
  assign pop       = mem_write;
  assign rmo       = entries[head].addr;
  assign wr_data   = entries[head].data;
  assign rmi       = ld_addr;

  sb_fwd_match #(
    .DEPTH(DEPTH)
  ) u_fwd (
    .entries(entries),
    .valid  (valid),
    .tail   (tail),
    .ld_addr(ld_addr),
    .hit    (fwd_hit),
    .data   (fwd_data)
  );

  // The incoming store is not yet in entries, so it never forwards to this load.
  assign ld_data = fwd_hit ? fwd_data : dm_out;

  // Push and pop never target the same slot: that needs head==tail, i.e. empty or full.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{addr: st_addr, data: st_data};
        valid[tail]   <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model with a
// per-cycle compare, directed scenarios, then randomized traffic.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       st_valid;
  logic [7:0] st_addr;
  logic [7:0] st_data;
  logic       st_ready;
  logic       drain_stall;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] dm_out;
  logic [7:0] rmi;
  logic       mem_write;
  logic [7:0] rmo;
  logic [7:0] wr_data;
  logic [$clog2(DEPTH):0] count;
  logic       empty;
  logic       full;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       q[$];
  logic [7:0] dm[256];
  logic [7:0] ref_dm[256];
  logic [7:0] snap[3];
  int         total = 0;
  int         bad = 0;
  bit         check_en = 1'b0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .drain_stall(drain_stall),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .dm_out     (dm_out),
    .rmi        (rmi),
    .mem_write  (mem_write),
    .rmo        (rmo),
    .wr_data    (wr_data),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  // Data memory: combinational read, write committed on the clock edge.
  assign dm_out = dm[rmi];

  always @(posedge clk) begin
    if (mem_write === 1'b1) dm[rmo] = wr_data;
  end

  // Reference model: the buffer is just an ordered queue of pending stores.
  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    do_pop  = (q.size() > 0) && !drain_stall;
    do_push = (st_valid === 1'b1) && (q.size() < DEPTH);
    if (do_pop) begin
      ref_dm[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (reset) q.delete();
    else if (do_push) q.push_back('{a: st_addr, d: st_data});
  end

  function automatic logic [7:0] model_ld(input logic [7:0] a);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == a) return q[i].d;
    end
    return ref_dm[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit exp_wr;
    exp_wr = (q.size() > 0) && !drain_stall;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
    chk("mem_write", 32'(mem_write), 32'(exp_wr));
    chk("rmi", 32'(rmi), 32'(ld_addr));
    chk("ld_data", 32'(ld_data), 32'(model_ld(ld_addr)));
    if (exp_wr) begin
      chk("rmo", 32'(rmo), 32'(q[0].a));
      chk("wr_data", 32'(wr_data), 32'(q[0].d));
    end
  endtask

  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] d,
                               input logic stall, input logic [7:0] la);
    st_valid    = v;
    st_addr     = a;
    st_data     = d;
    drain_stall = stall;
    ld_addr     = la;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dm[i]     = 8'($urandom);
      ref_dm[i] = dm[i];
    end
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    step(2);
    reset    = 1'b0;
    check_en = 1'b1;
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    // Single store: no bypass, drains the following cycle.
    applyStimulus(1'b1, 8'd10, 8'd155, 1'b0, 8'd0);
    #2 chk("nobypass_mw", 32'(mem_write), 32'd0);
    step(1);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    #2;
    chk("single_mw", 32'(mem_write), 32'd1);
    chk("single_rmo", 32'(rmo), 32'd10);
    chk("single_wd", 32'(wr_data), 32'd155);
    step(1);
    #2;
    chk("single_dm10", 32'(dm[10]), 32'd155);
    chk("single_empty", 32'(empty), 32'd1);

    // Fill while stalled, reject a fifth store, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(i), 8'(i * 3 + 1), 1'b1, 8'd0);
      step(1);
    end
    applyStimulus(1'b1, 8'd5, 8'd99, 1'b1, 8'd0);
    #2;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(st_ready), 32'd0);
    step(1);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    #2 chk("fill_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_mw", 32'(mem_write), 32'd1);
      chk("drain_rmo", 32'(rmo), 32'(i));
      chk("drain_wd", 32'(wr_data), 32'(i * 3 + 1));
      chk("drain_count", 32'(count), 32'(5 - i));
      step(1);
      #2;
    end
    chk("drain_empty", 32'(count), 32'd0);
    chk("drain_dm4", 32'(dm[4]), 32'd13);

    // Forwarding picks the youngest of two same-address stores.
    applyStimulus(1'b1, 8'd20, 8'd7, 1'b1, 8'd0);
    step(1);
    applyStimulus(1'b1, 8'd20, 8'd9, 1'b1, 8'd0);
    step(1);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd20);
    #2 chk("fwd_young", 32'(ld_data), 32'd9);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'd21);
    #2 chk("fwd_miss", 32'(ld_data), 32'(dm[21]));
    applyStimulus(1'b1, 8'd20, 8'h55, 1'b1, 8'd20);
    #2 chk("fwd_same_cycle", 32'(ld_data), 32'd9);
    step(1);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd20);
    #2 chk("fwd_head_drain", 32'(ld_data), 32'h55);
    step(4);
    chk("fwd_drained", 32'(empty), 32'd1);

    // Steady push+pop with two resident entries; pointers wrap several times.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'(40 + i), 8'(i + 1), 1'b1, 8'd0);
      step(1);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(50 + i), 8'(100 + i), 1'b0, 8'(48 + i));
      step(1);
      #2 chk("steady_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    step(3);
    chk("steady_dm59", 32'(dm[59]), 32'd109);

    // Reset discards pending stores; a store held during reset is dropped.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(100 + i), 8'(200 + i), 1'b1, 8'd0);
      step(1);
    end
    for (int i = 0; i < 3; i++) snap[i] = dm[100 + i];
    reset = 1'b1;
    applyStimulus(1'b1, 8'd103, 8'd77, 1'b1, 8'd0);
    step(1);
    reset = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("rst_pend_count", 32'(count), 32'd0);
      chk("rst_pend_mw", 32'(mem_write), 32'd0);
      step(1);
    end
    for (int i = 0; i < 3; i++) chk("rst_pend_dm", 32'(dm[100 + i]), 32'(snap[i]));

    // Randomized traffic on a narrow address range so forwarding hits often.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 15)), 8'($urandom),
                    ($urandom_range(0, 99) < 30), 8'($urandom_range(0, 15)));
      reset = ($urandom_range(0, 299) == 0);
      step(1);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
    step(DEPTH + 2);
    chk("final_empty", 32'(empty), 32'd1);
    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < 256; i++) if (dm[i] !== ref_dm[i]) diffs++;
      chk("final_dm", 32'(diffs), 32'd0);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
